fp_special_norm: RTL and testbench

Parametrised front-end for the floating-point square-root datapath: classifies an IEEE-754 operand of any exponent/mantissa width, resolves every special case to its final result, and normalises subnormals with an iterative shifter. Ready/valid handshakes on both sides let the sqrt core stall the front-end. The sqrt core consumes `out_mant` and `out_exp` only when `out_bypass` = 0.

---
 rtl/fp_special_pkg.sv | 26 ++
 rtl/fp_class_decode.sv | 62 ++++++
 rtl/fp_special_norm.sv | 133 +++++++++++++
 tb/tb_fp_special_norm.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_special_pkg.sv
// Shared definitions for the floating-point square-root front-end: class bit
// positions, the front-end FSM states and IEEE-754 field helpers.
package fp_special_pkg;

    localparam int CLS_NAN    = 5;
    localparam int CLS_PINF   = 4;
    localparam int CLS_NINF   = 3;
    localparam int CLS_ZERO   = 2;
    localparam int CLS_NORMAL = 1;
    localparam int CLS_SUB    = 0;

    typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

    function automatic int emax(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int quiet_bit(input int mw);
        return 1 << (mw - 1);
    endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational operand classifier and final-result generator for every
// operand whose square root needs no arithmetic.
module fp_class_decode
    import fp_special_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10
) (
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [MANT_W-1:0] mant_i,
    output logic [5:0]        cls_o,
    output logic              invalid_o,
    output logic              bypass_o,
    output logic              res_sign_o,
    output logic [EXP_W-1:0]  res_exp_o,
    output logic [MANT_W-1:0] res_mant_o,
    output logic              pos_norm_o,
    output logic              pos_sub_o
);

    localparam logic [EXP_W-1:0]  EMAX = EXP_W'(emax(EXP_W));
    localparam logic [MANT_W-1:0] QBIT = MANT_W'(quiet_bit(MANT_W));

    logic exp_max, exp_zero, mant_zero;

    always_comb begin
        exp_max   = (exp_i == EMAX);
        exp_zero  = (exp_i == '0);
        mant_zero = (mant_i == '0);

        cls_o             = '0;
        cls_o[CLS_NAN]    = exp_max && !mant_zero;
        cls_o[CLS_PINF]   = exp_max && mant_zero && !sign_i;
        cls_o[CLS_NINF]   = exp_max && mant_zero && sign_i;
        cls_o[CLS_ZERO]   = exp_zero && mant_zero;
        cls_o[CLS_NORMAL] = !exp_max && !exp_zero;
        cls_o[CLS_SUB]    = exp_zero && !mant_zero;

        // A signed NaN stays a NaN; only non-NaN, nonzero negatives are invalid.
        invalid_o  = sign_i && !cls_o[CLS_NAN] && !cls_o[CLS_ZERO];
        bypass_o   = sign_i || exp_max || cls_o[CLS_ZERO];
        pos_norm_o = !sign_i && cls_o[CLS_NORMAL];
        pos_sub_o  = !sign_i && cls_o[CLS_SUB];

        res_sign_o = sign_i;
        res_exp_o  = exp_i;
        res_mant_o = mant_i;
        if (cls_o[CLS_NAN]) begin
            res_mant_o = mant_i | QBIT;
        end else if (invalid_o) begin
            res_sign_o = 1'b1;
            res_exp_o  = EMAX;
            res_mant_o = QBIT;
        end else if (!bypass_o) begin
            res_sign_o = 1'b0;
            res_exp_o  = '0;
            res_mant_o = '0;
        end
    end

endmodule

// File: rtl/fp_special_norm.sv
// Square-root front-end: classifies the operand, resolves special results and
// normalises positive subnormals one bit per cycle behind a ready/valid pair.
module fp_special_norm
    import fp_special_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sign,
    input  logic [EXP_W-1:0]                  in_exp,
    input  logic [MANT_W-1:0]                 in_mant,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [5:0]                        out_class,
    output logic                              out_invalid,
    output logic                              out_bypass,
    output logic                              out_sign,
    output logic [EXP_W-1:0]                  out_res_exp,
    output logic [MANT_W-1:0]                 out_res_mant,
    output logic signed [EXP_W+1:0]           out_exp,
    output logic [MANT_W:0]                   out_mant,
    output logic                              out_exp_odd,
    output logic [$clog2(MANT_W+1)-1:0]       out_norm_shift
);

    localparam int SH_W = $clog2(MANT_W + 1);
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(bias(EXP_W));
    localparam logic signed [EXP_W+1:0] ONE_S  = 1;

    state_t state_q;

    logic [5:0]               cls_q;
    logic                     inv_q, byp_q, sign_q;
    logic [EXP_W-1:0]         rexp_q;
    logic [MANT_W-1:0]        rmant_q;
    logic signed [EXP_W+1:0]  exp_q, exp_d;
    logic [MANT_W:0]          mant_q, mant_d, mant_sh;
    logic [SH_W-1:0]          shift_q;

    logic [5:0]               dec_cls;
    logic                     dec_inv, dec_byp, dec_sign, dec_norm, dec_sub;
    logic [EXP_W-1:0]         dec_exp;
    logic [MANT_W-1:0]        dec_mant;
    logic                     accept;

    fp_class_decode #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_decode (
        .sign_i     (in_sign),
        .exp_i      (in_exp),
        .mant_i     (in_mant),
        .cls_o      (dec_cls),
        .invalid_o  (dec_inv),
        .bypass_o   (dec_byp),
        .res_sign_o (dec_sign),
        .res_exp_o  (dec_exp),
        .res_mant_o (dec_mant),
        .pos_norm_o (dec_norm),
        .pos_sub_o  (dec_sub)
    );

    assign in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    assign accept   = in_valid && in_ready;
    assign mant_sh  = {mant_q[MANT_W-1:0], 1'b0};

    // Subnormals start at the minimum normal exponent with hidden bit 0.
    always_comb begin
        exp_d  = '0;
        mant_d = '0;
        if (dec_norm) begin
            exp_d  = $signed({2'b00, in_exp}) - BIAS_S;
            mant_d = {1'b1, in_mant};
        end else if (dec_sub) begin
            exp_d  = ONE_S - BIAS_S;
            mant_d = {1'b0, in_mant};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cls_q   <= '0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
            sign_q  <= 1'b0;
            rexp_q  <= '0;
            rmant_q <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
            shift_q <= '0;
        end else if (accept) begin
            cls_q   <= dec_cls;
            inv_q   <= dec_inv;
            byp_q   <= dec_byp;
            sign_q  <= dec_sign;
            rexp_q  <= dec_exp;
            rmant_q <= dec_mant;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            shift_q <= '0;
            state_q <= dec_sub ? NORM : OUT;
        end else begin
            case (state_q)
                NORM: begin
                    mant_q  <= mant_sh;
                    exp_q   <= exp_q - ONE_S;
                    shift_q <= shift_q + SH_W'(1);
                    if (mant_sh[MANT_W]) state_q <= OUT;
                end
                OUT: if (out_ready) state_q <= IDLE;
                default: ;
            endcase
        end
    end

    assign out_valid      = (state_q == OUT);
    assign out_class      = cls_q;
    assign out_invalid    = inv_q;
    assign out_bypass     = byp_q;
    assign out_sign       = sign_q;
    assign out_res_exp    = rexp_q;
    assign out_res_mant   = rmant_q;
    assign out_exp        = exp_q;
    assign out_mant       = mant_q;
    assign out_exp_odd    = exp_q[0];
    assign out_norm_shift = shift_q;

endmodule

// File: tb/tb_fp_special_norm.sv
// Bench for fp_special_norm: fp16 vector table and corner sequences, then an
// fp32 instance driven with random operands against a reference model.
module tb_fp_special_norm;

    typedef struct {
        logic [5:0] cls;
        bit         inv;
        bit         byp;
        longint     res;
        longint     ex;
        longint     mant;
        longint     sh;
        int         lat;
    } exp_t;

    typedef struct {
        logic [15:0] op;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, is16, ov16, or16, oinv16, obyp16, os16, oodd16;
    logic [4:0]  ie16, ore16;
    logic [9:0]  im16, orm16;
    logic [5:0]  oc16;
    logic signed [6:0] oexp16;
    logic [10:0] om16;
    logic [3:0]  osh16;

    logic        iv32, ir32, is32, ov32, or32, oinv32, obyp32, os32, oodd32;
    logic [7:0]  ie32, ore32;
    logic [22:0] im32, orm32;
    logic [5:0]  oc32;
    logic signed [9:0] oexp32;
    logic [23:0] om32;
    logic [4:0]  osh32;

    fp_special_norm u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_sign(is16),
        .in_exp(ie16), .in_mant(im16), .out_valid(ov16), .out_ready(or16),
        .out_class(oc16), .out_invalid(oinv16), .out_bypass(obyp16), .out_sign(os16),
        .out_res_exp(ore16), .out_res_mant(orm16), .out_exp(oexp16), .out_mant(om16),
        .out_exp_odd(oodd16), .out_norm_shift(osh16)
    );

    fp_special_norm #(.EXP_W(8), .MANT_W(23)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_sign(is32),
        .in_exp(ie32), .in_mant(im32), .out_valid(ov32), .out_ready(or32),
        .out_class(oc32), .out_invalid(oinv32), .out_bypass(obyp32), .out_sign(os32),
        .out_res_exp(ore32), .out_res_mant(orm32), .out_exp(oexp32), .out_mant(om32),
        .out_exp_odd(oodd32), .out_norm_shift(osh32)
    );

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] c, input bit inv, input bit byp,
                                input longint res, input longint ex, input longint mant,
                                input longint sh, input int lat);
        exp_t r;
        r.cls = c; r.inv = inv; r.byp = byp; r.res = res;
        r.ex = ex; r.mant = mant; r.sh = sh; r.lat = lat;
        return r;
    endfunction

    // Square-root front-end behaviour from the IEEE field values.
    function automatic exp_t model(input int ew, input int mw, input longint op);
        exp_t   r;
        longint one  = 1;
        longint emax = (one << ew) - 1;
        longint bias = (one << (ew - 1)) - 1;
        longint q    = one << (mw - 1);
        longint s    = (op >> (ew + mw)) & 1;
        longint e    = (op >> mw) & emax;
        longint m    = op & ((one << mw) - 1);
        r = mk(6'b0, 0, 0, 0, 0, 0, 0, 1);
        if (e == emax && m != 0) begin
            r.cls = 6'b100000; r.byp = 1; r.res = op | q;
        end else if (e == emax) begin
            r.cls = s != 0 ? 6'b001000 : 6'b010000; r.byp = 1;
            if (s != 0) begin r.inv = 1; r.res = (one << (ew + mw)) | (emax << mw) | q; end
            else r.res = op;
        end else if (e == 0 && m == 0) begin
            r.cls = 6'b000100; r.byp = 1; r.res = op;
        end else begin
            r.cls = (e == 0) ? 6'b000001 : 6'b000010;
            if (s != 0) begin
                r.inv = 1; r.byp = 1; r.res = (one << (ew + mw)) | (emax << mw) | q;
            end else if (e != 0) begin
                r.ex = e - bias; r.mant = m | (one << mw);
            end else begin
                r.mant = m; r.ex = 1 - bias;
                while (r.mant < (one << mw)) begin
                    r.mant = r.mant * 2; r.ex = r.ex - 1; r.sh = r.sh + 1;
                end
                r.lat = int'(r.sh) + 1;
            end
        end
        return r;
    endfunction

    task automatic cmp16(input string nm, input exp_t w);
        chk({nm, ".class"}, longint'(oc16), longint'(w.cls));
        chk({nm, ".invalid"}, longint'(oinv16), longint'(w.inv));
        chk({nm, ".bypass"}, longint'(obyp16), longint'(w.byp));
        if (w.byp) chk({nm, ".res"}, longint'({os16, ore16, orm16}), w.res);
        else begin
            chk({nm, ".exp"}, longint'(oexp16), w.ex);
            chk({nm, ".mant"}, longint'(om16), w.mant);
            chk({nm, ".shift"}, longint'(osh16), w.sh);
            chk({nm, ".odd"}, longint'(oodd16), w.ex & 1);
        end
    endtask

    task automatic cmp32(input string nm, input exp_t w);
        chk({nm, ".class"}, longint'(oc32), longint'(w.cls));
        chk({nm, ".invalid"}, longint'(oinv32), longint'(w.inv));
        chk({nm, ".bypass"}, longint'(obyp32), longint'(w.byp));
        if (w.byp) chk({nm, ".res"}, longint'({os32, ore32, orm32}), w.res);
        else begin
            chk({nm, ".exp"}, longint'(oexp32), w.ex);
            chk({nm, ".mant"}, longint'(om32), w.mant);
            chk({nm, ".shift"}, longint'(osh32), w.sh);
            chk({nm, ".odd"}, longint'(oodd32), w.ex & 1);
        end
    endtask

    task automatic apply16(input string nm, input logic [15:0] op, input exp_t w);
        int n;
        @(negedge clk);
        {is16, ie16, im16} = op; iv16 = 1'b1; or16 = 1'b1;
        #1;
        n = 0;
        while (!ir16 && n < 40) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 1;
        while (!ov16 && n < 60) begin @(posedge clk); #1; n++; end
        chk({nm, ".lat"}, n, w.lat);
        cmp16(nm, w);
    endtask

    function automatic logic [31:0] rand32();
        logic [7:0]  e;
        logic [22:0] m;
        int k = $urandom_range(0, 7);
        e = (k < 3) ? 8'h00 : (k == 3) ? 8'hFF : 8'($urandom);
        m = 23'($urandom) >> $urandom_range(0, 23);
        return {($urandom_range(0, 3) == 0), e, m};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    vec_t tbl[15];
    logic [15:0] b2b[3];
    exp_t sb[$];

    initial begin
        int n;
        bit saw;
        bit acc;
        int acc_n;
        logic [31:0] op32;
        exp_t w;

        tbl[0]  = '{16'h3C00, mk(6'b000010, 0, 0, 0,        0,   'h400, 0,  1)};
        tbl[1]  = '{16'h4000, mk(6'b000010, 0, 0, 0,        1,   'h400, 0,  1)};
        tbl[2]  = '{16'h4400, mk(6'b000010, 0, 0, 0,        2,   'h400, 0,  1)};
        tbl[3]  = '{16'h7BFF, mk(6'b000010, 0, 0, 0,        15,  'h7FF, 0,  1)};
        tbl[4]  = '{16'h0001, mk(6'b000001, 0, 0, 0,        -24, 'h400, 10, 11)};
        tbl[5]  = '{16'h0200, mk(6'b000001, 0, 0, 0,        -15, 'h400, 1,  2)};
        tbl[6]  = '{16'h03FF, mk(6'b000001, 0, 0, 0,        -15, 'h7FE, 1,  2)};
        tbl[7]  = '{16'h0010, mk(6'b000001, 0, 0, 0,        -20, 'h400, 6,  7)};
        tbl[8]  = '{16'h7D01, mk(6'b100000, 0, 1, 'h7F01,   0,   0,     0,  1)};
        tbl[9]  = '{16'hBC00, mk(6'b000010, 1, 1, 'hFE00,   0,   0,     0,  1)};
        tbl[10] = '{16'hFC00, mk(6'b001000, 1, 1, 'hFE00,   0,   0,     0,  1)};
        tbl[11] = '{16'h8000, mk(6'b000100, 0, 1, 'h8000,   0,   0,     0,  1)};
        tbl[12] = '{16'h8001, mk(6'b000001, 1, 1, 'hFE00,   0,   0,     0,  1)};
        tbl[13] = '{16'hFE00, mk(6'b100000, 0, 1, 'hFE00,   0,   0,     0,  1)};
        tbl[14] = '{16'h0000, mk(6'b000100, 0, 1, 'h0000,   0,   0,     0,  1)};
        b2b = '{16'h3C00, 16'h4000, 16'h4400};

        rst = 1'b1;
        iv16 = 1'b0; or16 = 1'b1; is16 = 1'b0; ie16 = '0; im16 = '0;
        iv32 = 1'b0; or32 = 1'b1; is32 = 1'b0; ie32 = '0; im32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", longint'(ov16), 0);
        chk("reset.in_ready", longint'(ir16), 1);
        chk("reset.class", longint'(oc16), 0);
        chk("reset.flags", longint'({oinv16, obyp16, os16}), 0);
        chk("reset.mant", longint'(om16), 0);
        chk("reset.shift", longint'(osh16), 0);
        chk("reset.out_valid32", longint'(ov32), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) apply16($sformatf("vec%0d", i), tbl[i].op, tbl[i].e);

        // Stall: result must hold while downstream is not ready.
        @(posedge clk); #1;
        chk("drain1.out_valid", longint'(ov16), 0);
        @(negedge clk);
        or16 = 1'b0; {is16, ie16, im16} = 16'h3C00; iv16 = 1'b1;
        @(posedge clk); #1;
        {is16, ie16, im16} = 16'h4000;
        chk("hold.valid", longint'(ov16), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("hold.in_ready", longint'(ir16), 0);
            chk("hold.out_valid", longint'(ov16), 1);
            chk("hold.exp", longint'(oexp16), 0);
            chk("hold.mant", longint'(om16), 'h400);
        end
        @(negedge clk);
        or16 = 1'b1; #1;
        chk("release.in_ready", longint'(ir16), 1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        chk("release.out_valid", longint'(ov16), 1);
        chk("release.exp", longint'(oexp16), 1);
        chk("release.odd", longint'(oodd16), 1);
        @(posedge clk); #1;

        // One result per cycle with out_ready held high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {is16, ie16, im16} = b2b[i]; iv16 = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("b2b%0d.valid", i), longint'(ov16), 1);
            chk($sformatf("b2b%0d.exp", i), longint'(oexp16), i);
        end
        iv16 = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of normalisation discards the operand.
        @(negedge clk);
        {is16, ie16, im16} = 16'h0001; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_norm.out_valid", longint'(ov16), 0);
        chk("rst_norm.in_ready", longint'(ir16), 1);
        saw = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (ov16) saw = 1'b1; end
        chk("rst_norm.no_output", longint'(saw), 0);
        apply16("pinf", 16'h7C00, mk(6'b010000, 0, 1, 'h7C00, 0, 0, 0, 1));
        @(posedge clk); #1;

        // Reset while a stalled result is presented.
        @(negedge clk);
        or16 = 1'b0; {is16, ie16, im16} = 16'h3C00; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        chk("rst_out.before", longint'(ov16), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; or16 = 1'b1;
        chk("rst_out.after", longint'(ov16), 0);
        chk("rst_out.in_ready", longint'(ir16), 1);

        // fp32 smallest subnormal.
        @(negedge clk);
        {is32, ie32, im32} = 32'h0000_0001; iv32 = 1'b1; or32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        n = 1;
        while (!ov32 && n < 60) begin @(posedge clk); #1; n++; end
        chk("fp32min.lat", n, 24);
        cmp32("fp32min", mk(6'b000001, 0, 0, 0, -149, 'h800000, 23, 24));
        @(posedge clk); #1;
        chk("drain32.out_valid", longint'(ov32), 0);

        // Random fp32 stream with random backpressure.
        acc = 1'b1;
        acc_n = 0;
        op32 = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 8000 && acc_n < 300; cyc++) begin
            or32 = ($urandom_range(0, 3) != 0);
            if (!iv32 || acc) begin
                iv32 = ($urandom_range(0, 2) != 0);
                op32 = rand32();
                {is32, ie32, im32} = op32;
            end
            #1;
            if (ov32 && or32) begin
                if (sb.size() == 0) chk("rnd.spurious", 1, 0);
                else begin
                    w = sb.pop_front();
                    cmp32("rnd", w);
                end
            end
            acc = iv32 && ir32;
            if (acc) begin
                sb.push_back(model(8, 23, longint'(op32)));
                acc_n++;
            end
            @(negedge clk);
        end
        iv32 = 1'b0; or32 = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            #1;
            if (ov32) begin
                w = sb.pop_front();
                cmp32("rnd", w);
            end
            @(negedge clk);
            n++;
        end
        chk("rnd.drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
